serial_adder: RTL



---
 rtl/serial_adder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder with a start/busy/done handshake.
// Operands are captured on an accepted start, then one bit is added per clock,
// LSB first, through a single full-adder slice and a carry flip-flop. The sum
// and carry-out are published on the last bit and held until the next result.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   Defined   - adds a 'sub' input captured with start; sub=1 switches the slice
//               to a full subtractor (cin is borrow-in, cout is final borrow).
//   Undefined - add-only, no 'sub' port.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=2.
  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q,  res_d;
  logic [WIDTH-1:0] sum_q,  sum_d;
  logic             carry_q, carry_d;
  logic             cout_q,  cout_d;
  logic [CntW-1:0]  cnt_q,   cnt_d;

  // Operation mode for the in-flight operation (1 = subtract).
  logic mode_sub;

  // Single-bit slice outputs.
  logic slice_a, slice_b;
  logic slice_s, slice_c;
  logic last_bit;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;

  // Mode flag is captured with the operands and held for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end

  // Capture sub only when a start is accepted in idle.
  always_comb begin
    sub_d = sub_q;
    if (state_q == StIdle && start) begin
      sub_d = sub;
    end
  end

  assign mode_sub = sub_q;
`else
  assign mode_sub = 1'b0;
`endif

  assign slice_a  = a_sh_q[0];
  assign slice_b  = b_sh_q[0];
  assign last_bit = (cnt_q == CntLast);

  // One full-adder (or full-subtractor) slice on the current LSBs and carry.
  always_comb begin
    slice_s = slice_a ^ slice_b ^ carry_q;
    slice_c = (slice_a & slice_b) | (slice_a & carry_q) | (slice_b & carry_q);
    if (mode_sub) begin
      // Borrow out: a<b, or a==b with a borrow already pending.
      slice_c = (~slice_a & slice_b) | (~(slice_a ^ slice_b) & carry_q);
    end
  end

  // State, datapath and result registers; reset discards any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath control; everything holds unless the state acts on it.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        // Result bits enter at the MSB so that after WIDTH shifts bit 0 is the LSB.
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {slice_s, res_q[WIDTH-1:1]};
        carry_d = slice_c;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          sum_d   = {slice_s, res_q[WIDTH-1:1]};
          cout_d  = slice_c;
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs decode straight from the registered state.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule
